// File: rtl/fp_wb_arbiter_pkg.sv
// FPU writeback arbiter shared types.
// Result/id types and the unit index helper.
package fp_wb_arbiter_pkg;

    localparam int MAX_UNITS = 8;
    localparam int ID_W      = 3;
    localparam int FLOPOCO_W = 34;

    typedef logic [ID_W-1:0]      id_t;
    typedef logic [FLOPOCO_W-1:0] flopoco_t;

    typedef logic [$clog2(MAX_UNITS)-1:0] fp_wb_unit_idx_t;

    // Next unit index, wrapping explicitly at n-1.
    function automatic fp_wb_unit_idx_t wrap_inc(fp_wb_unit_idx_t idx, int n);
        if (int'(idx) >= n - 1) return '0;
        return idx + 1'b1;
    endfunction

endpackage

// File: rtl/fp_wb_arbiter_if.sv
// Unit writeback and commit-path bundle.
// master = arbiter side, slave = units plus commit path.
interface fp_wb_arbiter_if
    import fp_wb_arbiter_pkg::*;
#(
    parameter int NUM_UNITS  = 4,
    parameter int DATA_WIDTH = FLOPOCO_W,
    parameter int ID_WIDTH   = ID_W
);

    localparam int IDX_W = $clog2(NUM_UNITS);

    logic [NUM_UNITS-1:0]                 unit_done;
    logic [NUM_UNITS-1:0][DATA_WIDTH-1:0] unit_rd;
    logic [NUM_UNITS-1:0][ID_WIDTH-1:0]   unit_id;
    logic [NUM_UNITS-1:0]                 unit_ack;

    logic                  commit_valid;
    logic                  commit_ready;
    logic [DATA_WIDTH-1:0] commit_data;
    logic [ID_WIDTH-1:0]   commit_id;
    logic [IDX_W-1:0]      commit_unit;

    modport master (
        input  unit_done, unit_rd, unit_id, commit_ready,
        output unit_ack, commit_valid, commit_data,
        output commit_id, commit_unit
    );

    modport slave (
        output unit_done, unit_rd, unit_id, commit_ready,
        input  unit_ack, commit_valid, commit_data,
        input  commit_id, commit_unit
    );

endinterface

// File: rtl/fp_wb_arbiter_rr_priority_arbiter.sv
// Combinational priority picker with optional rotating start.
// The rotation pointer is owned by the caller.
module rr_priority_arbiter
    import fp_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ROUND_ROBIN = 1,
    localparam int IDX_W      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any_grant
);

    // Scan upward from the start point, first set request wins.
    always_comb begin
        int start;
        int j;
        grant     = '0;
        idx       = '0;
        any_grant = 1'b0;
        start     = (ROUND_ROBIN != 0) ? int'(rr_ptr) : 0;
        j         = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = start + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!any_grant && req[j[IDX_W-1:0]]) begin
                any_grant            = 1'b1;
                grant[j[IDX_W-1:0]]  = 1'b1;
                idx                  = j[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/fp_wb_arbiter.sv
// FPU writeback collector: one winner per cycle into a
// registered commit stage with valid/ready backpressure.
module fp_wb_arbiter
    import fp_wb_arbiter_pkg::*;
#(
    parameter int NUM_UNITS   = 4,
    parameter int DATA_WIDTH  = FLOPOCO_W,
    parameter int ID_WIDTH    = ID_W,
    parameter int ROUND_ROBIN = 1
) (
    input logic            clk,
    input logic            rst,
    fp_wb_arbiter_if.master bus
);

    localparam int IDX_W = $clog2(NUM_UNITS);

    logic                  advance;
    logic                  any_grant;
    logic [NUM_UNITS-1:0]  grant;
    logic [IDX_W-1:0]      gidx;
    logic [IDX_W-1:0]      rr_ptr;
    logic [IDX_W-1:0]      rr_next;

    logic                  valid_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic [IDX_W-1:0]      unit_q;

    rr_priority_arbiter #(
        .NUM_REQ     (NUM_UNITS),
        .ROUND_ROBIN (ROUND_ROBIN)
    ) u_arb (
        .req       (bus.unit_done),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .idx       (gidx),
        .any_grant (any_grant)
    );

    // Stage can take a new result when empty or draining.
    assign advance = !valid_q || bus.commit_ready;

    assign rr_next = IDX_W'(wrap_inc(fp_wb_unit_idx_t'(gidx), NUM_UNITS));

    assign bus.unit_ack = (advance && !rst) ? grant : '0;

    // Commit stage register and rotation pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            id_q    <= '0;
            unit_q  <= '0;
            rr_ptr  <= '0;
        end else if (advance) begin
            valid_q <= any_grant;
            if (any_grant) begin
                data_q <= bus.unit_rd[gidx];
                id_q   <= bus.unit_id[gidx];
                unit_q <= gidx;
                rr_ptr <= rr_next;
            end
        end
    end

    assign bus.commit_valid = valid_q;
    assign bus.commit_data  = data_q;
    assign bus.commit_id    = id_q;
    assign bus.commit_unit  = unit_q;

    a_ack_onehot: assert property (
        @(posedge clk) $onehot0(bus.unit_ack));

    a_ack_done: assert property (
        @(posedge clk) (bus.unit_ack & ~bus.unit_done) == '0);

    a_hold: assert property (
        @(posedge clk) disable iff (rst)
        (bus.commit_valid && !bus.commit_ready) |=>
        ($stable(bus.commit_data) && $stable(bus.commit_id)));

endmodule

// File: doc/fp_wb_arbiter.md
Name: fp_wb_arbiter

Overview:
- Writeback collector on the consumer side of the unit writeback handshake (done/rd/id from unit, ack back to unit).
- Arbitrates among NUM_UNITS FPU execution units (div/sqrt, FMA, convert, misc), each of which holds its result until acked.
- Registers one winner per cycle into an output stage that drives the FP register-file commit path with its own valid/ready handshake.

Parameters:
- NUM_UNITS, 4, number of attached FPU units; legal range 2..8.
- DATA_WIDTH, 34, result width (flopoco single-precision: 2 exception bits + sign + 8 exp + 23 mantissa).
- ID_WIDTH, 3, instruction id width (matches id_t).
- ROUND_ROBIN, 1, 1 = rotating priority; 0 = fixed priority, lowest index wins.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- unit_done  in  NUM_UNITS  per-unit result valid; held high until acked.
- unit_rd  in  NUM_UNITS x DATA_WIDTH  per-unit result data.
- unit_id  in  NUM_UNITS x ID_WIDTH  per-unit instruction id.
- unit_ack  out  NUM_UNITS  per-unit accept, one-hot or zero.
- commit_valid  out  1  output stage holds a result.
- commit_ready  in  1  commit path accepts the result this cycle.
- commit_data  out  DATA_WIDTH  registered result.
- commit_id  out  ID_WIDTH  registered id.
- commit_unit  out  clog2(NUM_UNITS)  index of the source unit, for trace and perf.

Behaviour:
- Reset values: commit_valid=0, commit_data=0, commit_id=0, commit_unit=0, rr_ptr=0. unit_ack is forced to all-zero while rst is high.
- advance = !commit_valid || commit_ready.
- Grant (combinational): one-hot over unit_done.
  - ROUND_ROBIN=1: search starts at rr_ptr and wraps upward (rr_ptr, rr_ptr+1, ... NUM_UNITS-1, 0, ...).
  - ROUND_ROBIN=0: lowest set index wins.
- unit_ack[i] = grant[i] && advance && !rst. The ack is asserted in the same cycle the result is captured.
- On advance:
  - commit_valid <= |unit_done.
  - If any unit is done: commit_data, commit_id and commit_unit are loaded from the granted unit, and rr_ptr <= granted index + 1, wrapping to 0 past NUM_UNITS-1.
  - If no unit is done: data, id, unit and rr_ptr hold.
- No advance: all state holds and unit_ack=0. Units keep done, rd and id stable.
- Latency: 1 cycle from an acked unit_done to commit_valid.
- Throughput: 1 result per cycle when commit_ready is held high.
- Back-to-back: commit_ready=1 with a pending done in the same cycle retires the old result and captures the new one in that cycle; there is no bubble.
- Starvation bound (ROUND_ROBIN=1): a held request is granted within NUM_UNITS advance cycles.
- Reset mid-operation: the pending commit is discarded (commit_valid=0) and no ack is issued during reset. Units are reset by the same rst and drop done.
- Arithmetic: rr_ptr is clog2(NUM_UNITS) bits. For non-power-of-2 NUM_UNITS the increment wraps explicitly at NUM_UNITS-1, never by overflow.
- Assertions:
  - unit_ack is onehot0.
  - A unit's ack implies its done.
  - commit_data and commit_id are stable while commit_valid && !commit_ready.

Decomposition:
- id_t and flopoco_t come from the existing shared types package.
- Add fp_wb_unit_idx_t (clog2 of the maximum of 8 units) to the FPU package.
- Sub-module rr_priority_arbiter: parameterised NUM_REQ and ROUND_ROBIN.
  - Inputs: request vector, rr_ptr.
  - Outputs: one-hot grant, granted index, any_grant.
  - Purely combinational; rr_ptr lives in fp_wb_arbiter.

Test Plan:
- Single request: after reset, unit_done=0b0010, unit_id[1]=5, unit_rd[1]=0x0_3F800000, commit_ready=1 -> unit_ack=0b0010 in that cycle; next cycle commit_valid=1, commit_id=5, commit_data=0x0_3F800000, commit_unit=1.
- Round-robin fairness: all four done held continuously, commit_ready=1 -> grant order 0,1,2,3,0,1 on consecutive cycles, with no idle cycle.
- Backpressure: commit_ready=0 for 3 cycles with units 0 and 2 done -> unit_ack=0, commit outputs stable. On commit_ready=1, unit 2 is acked in that cycle (rr_ptr=1 after unit 0 was granted), with no lost or duplicated id.
- Fixed priority (ROUND_ROBIN=0): units 3 and 1 done -> unit 1 granted first, unit 3 on the next cycle.
- Wrap with NUM_UNITS=3: unit 2 granted, then units 0 and 2 request -> unit 0 granted (rr_ptr wrapped to 0).
- Reset mid-operation: commit_valid=1 with commit_ready=0 and rst pulsed for 1 cycle -> commit_valid=0 and unit_ack=0 during reset, rr_ptr=0 afterwards.
